// File: rtl/shift_unit_pipe.sv
// Two-stage pipelined shifter/rotator with a valid/ready handshake on both sides.
// Stage 1 registers the accepted operand, amount and opcode; stage 2 registers
// the computed result and its flags. A stalled output freezes both stages.
module shift_unit_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   shift,
  input  logic [2:0]       shift_operation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout_shift,
  output logic             carry_out,
  output logic             overflow,
  output logic             op_err
);

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SLA = 3'b001,
    OP_SRL = 3'b010,
    OP_SRA = 3'b011,
    OP_ROL = 3'b100,
    OP_ROR = 3'b101
  } op_e;

  // Stage 1 registers
  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [SHW-1:0]   s1_shift_q;
  logic [2:0]       s1_op_q;

  // Stage 2 registers
  logic             s2_valid_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic             ovf_q;
  logic             err_q;

  // Next-state values for stage 2
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             ovf_d;
  logic             err_d;

  // Handshake and datapath intermediates
  logic                    stall_s;
  logic                    accept_s;
  logic                    sh_nz_s;
  logic [WIDTH:0]          lsh_s;
  logic [WIDTH:0]          rsh_s;
  logic signed [WIDTH:0]   ash_s;
  logic [2*WIDTH-1:0]      rol_s;
  logic [2*WIDTH-1:0]      ror_s;
  logic [WIDTH-1:0]        sla_mask_s;
  logic [WIDTH-1:0]        sla_top_s;

  // Reset keeps in_ready high so a stale output cannot block the input side.
  assign stall_s  = s2_valid_q && !out_ready;
  assign in_ready = RESET || !stall_s;
  assign accept_s = in_valid && in_ready;

  assign out_valid    = s2_valid_q;
  assign aluout_shift = res_q;
  assign carry_out    = carry_q;
  assign overflow     = ovf_q;
  assign op_err       = err_q;

  // Compute the shift result and flags from the stage-1 contents.
  always_comb begin
    sh_nz_s = |s1_shift_q;
    // One extra bit on the exit side of each shift catches the last bit out;
    // it is naturally zero when the amount is zero.
    lsh_s   = {1'b0, s1_data_q} << s1_shift_q;
    rsh_s   = {s1_data_q, 1'b0} >> s1_shift_q;
    ash_s   = $signed({s1_data_q, 1'b0}) >>> s1_shift_q;
    // Rotations: shift a doubled copy and take the appropriate half.
    rol_s   = {s1_data_q, s1_data_q} << s1_shift_q;
    ror_s   = {s1_data_q, s1_data_q} >> s1_shift_q;
    // Mask of the top (shift+1) bits that must all agree for SLA to keep its sign.
    sla_mask_s = ~({WIDTH{1'b1}} >> ({1'b0, s1_shift_q} + {{SHW{1'b0}}, 1'b1}));
    sla_top_s  = s1_data_q & sla_mask_s;

    res_d   = s1_data_q;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    err_d   = 1'b0;
    case (s1_op_q)
      OP_SLL: begin
        res_d   = lsh_s[WIDTH-1:0];
        carry_d = lsh_s[WIDTH];
      end
      OP_SLA: begin
        res_d   = lsh_s[WIDTH-1:0];
        carry_d = lsh_s[WIDTH];
        ovf_d   = sh_nz_s && (sla_top_s != {WIDTH{1'b0}}) && (sla_top_s != sla_mask_s);
      end
      OP_SRL: begin
        res_d   = rsh_s[WIDTH:1];
        carry_d = rsh_s[0];
      end
      OP_SRA: begin
        res_d   = ash_s[WIDTH:1];
        carry_d = ash_s[0];
      end
      OP_ROL: begin
        res_d   = rol_s[2*WIDTH-1:WIDTH];
        carry_d = sh_nz_s && rol_s[WIDTH];
      end
      OP_ROR: begin
        res_d   = ror_s[WIDTH-1:0];
        carry_d = sh_nz_s && ror_s[WIDTH-1];
      end
      default: begin
        res_d   = s1_data_q;
        carry_d = 1'b0;
        ovf_d   = 1'b0;
        err_d   = 1'b1;
      end
    endcase
  end

  // Pipeline registers: clear on reset, freeze on stall, otherwise advance.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= {WIDTH{1'b0}};
      s1_shift_q <= {SHW{1'b0}};
      s1_op_q    <= 3'b000;
      s2_valid_q <= 1'b0;
      res_q      <= {WIDTH{1'b0}};
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else if (!stall_s) begin
      s1_valid_q <= accept_s;
      if (accept_s) begin
        s1_data_q  <= in_data;
        s1_shift_q <= shift;
        s1_op_q    <= shift_operation;
      end
      s2_valid_q <= s1_valid_q;
      // Outputs keep their last values when no new result arrives.
      if (s1_valid_q) begin
        res_q   <= res_d;
        carry_q <= carry_d;
        ovf_q   <= ovf_d;
        err_q   <= err_d;
      end
    end
  end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (WIDTH=32): a vector table for single
// operations plus sequences for throughput, backpressure and mid-flight reset.
module tb_shift_unit_pipe;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  shift;
  logic [2:0]  shift_operation;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] aluout_shift;
  logic        carry_out;
  logic        overflow;
  logic        op_err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] got_q[$];
  int          cyc_q[$];

  typedef struct packed {
    logic [31:0] din;
    logic [4:0]  sh;
    logic [2:0]  op;
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        e;
  } vec_t;

  vec_t vt[15];

  shift_unit_pipe #(.WIDTH(32)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .shift(shift),
    .shift_operation(shift_operation),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .aluout_shift(aluout_shift),
    .carry_out(carry_out),
    .overflow(overflow),
    .op_err(op_err)
  );

  always #5 CLOCK = ~CLOCK;

  always @(posedge CLOCK) cyc <= cyc + 1;

  // Record every consumed result, sampled well away from the active edge.
  always @(negedge CLOCK) begin
    #2;
    if (!RESET && out_valid && out_ready) begin
      got_q.push_back(aluout_shift);
      cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_results(input int n, input int budget);
    int w;
    w = 0;
    while (got_q.size() < n && w < budget) begin
      @(posedge CLOCK); #1;
      w++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acc;
    int guard;
    int w;

    // Table: din, shift, op, expected result, carry, overflow, op_err
    vt[0]  = '{32'h8000_0000, 5'd4,  3'b011, 32'hF800_0000, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{32'h0000_0001, 5'd1,  3'b101, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vt[2]  = '{32'h8000_0000, 5'd1,  3'b100, 32'h0000_0001, 1'b1, 1'b0, 1'b0};
    vt[3]  = '{32'h4000_0000, 5'd1,  3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vt[4]  = '{32'hC000_0000, 5'd1,  3'b001, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vt[5]  = '{32'h1234_5678, 5'd5,  3'b110, 32'h1234_5678, 1'b0, 1'b0, 1'b1};
    vt[6]  = '{32'h1234_5678, 5'd0,  3'b010, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vt[7]  = '{32'h0000_0001, 5'd31, 3'b000, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vt[8]  = '{32'h0000_000F, 5'd2,  3'b010, 32'h0000_0003, 1'b1, 1'b0, 1'b0};
    vt[9]  = '{32'h1234_5678, 5'd0,  3'b100, 32'h1234_5678, 1'b0, 1'b0, 1'b0};
    vt[10] = '{32'hFFFF_FFFF, 5'd3,  3'b111, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1};
    vt[11] = '{32'h8000_0001, 5'd1,  3'b000, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
    vt[12] = '{32'h7FFF_FFFF, 5'd31, 3'b011, 32'h0000_0000, 1'b1, 1'b0, 1'b0};
    vt[13] = '{32'hFFFF_FFFF, 5'd31, 3'b001, 32'h8000_0000, 1'b1, 1'b0, 1'b0};
    vt[14] = '{32'h0000_0001, 5'd31, 3'b001, 32'h8000_0000, 1'b0, 1'b1, 1'b0};

    RESET = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    shift = 5'd0;
    shift_operation = 3'b000;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(posedge CLOCK);
    @(negedge CLOCK);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_result", aluout_shift, 32'h0);
    chk("reset_flags", {carry_out, overflow, op_err}, 3'b000);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    out_ready = 1'b1;

    // Single operations with a free-running consumer
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_data = vt[i].din;
      shift = vt[i].sh;
      shift_operation = vt[i].op;
      @(posedge CLOCK); #1;
      in_valid = 1'b0;
      in_data = 32'hDEAD_BEEF;
      lat = 0;
      do begin
        @(posedge CLOCK); #1;
        lat++;
      end while (!out_valid && lat < 6);
      chk($sformatf("vec%0d_latency", i), lat, 1);
      chk($sformatf("vec%0d_result", i), aluout_shift, vt[i].res);
      chk($sformatf("vec%0d_carry", i), carry_out, vt[i].c);
      chk($sformatf("vec%0d_overflow", i), overflow, vt[i].o);
      chk($sformatf("vec%0d_op_err", i), op_err, vt[i].e);
    end
    repeat (3) @(posedge CLOCK); #1;

    // Back-to-back stream: one result per cycle, in order
    got_q.delete();
    cyc_q.delete();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data = 32'(k + 5);
      shift = 5'd2;
      shift_operation = 3'b000;
      @(posedge CLOCK); #1;
    end
    in_valid = 1'b0;
    wait_results(4, 20);
    chk("stream_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("stream_val%0d", k), got_q[k], 32'((k + 5) * 4));
        chk($sformatf("stream_cycle%0d", k), cyc_q[k] - cyc_q[0], k);
      end
    end

    // Backpressure: 1,2,3 shifted left by 1, consumer stalls 3 cycles on the first result
    got_q.delete();
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          in_valid = 1'b1;
          in_data = 32'(k + 1);
          shift = 5'd1;
          shift_operation = 3'b000;
          acc = 0;
          guard = 0;
          while (acc == 0 && guard < 20) begin
            @(negedge CLOCK); #1;
            acc = in_ready ? 1 : 0;
            @(posedge CLOCK); #1;
            guard++;
          end
        end
        in_valid = 1'b0;
      end
      begin
        w = 0;
        @(negedge CLOCK);
        while (!out_valid && w < 10) begin
          @(negedge CLOCK);
          w++;
        end
        for (int c = 0; c < 3; c++) begin
          chk($sformatf("bp_stall%0d_valid", c), out_valid, 1'b1);
          chk($sformatf("bp_stall%0d_in_ready", c), in_ready, 1'b0);
          chk($sformatf("bp_stall%0d_result", c), aluout_shift, 32'h2);
          if (c < 2) @(negedge CLOCK);
        end
        out_ready = 1'b1;
      end
    join
    wait_results(3, 20);
    repeat (5) @(posedge CLOCK); #1;
    chk("bp_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("bp_val0", got_q[0], 32'h2);
      chk("bp_val1", got_q[1], 32'h4);
      chk("bp_val2", got_q[2], 32'h6);
    end

    // Reset with two requests in flight; neither result may ever appear
    got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 32'h111;
    shift = 5'd1;
    shift_operation = 3'b000;
    @(posedge CLOCK); #1;
    in_data = 32'h333;
    @(posedge CLOCK); #1;
    chk("rst_pre_valid", out_valid, 1'b1);
    in_data = 32'h555;
    RESET = 1'b1;
    @(negedge CLOCK);
    chk("rst_in_ready", in_ready, 1'b1);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rst_post_valid", out_valid, 1'b0);
    chk("rst_post_result", aluout_shift, 32'h0);
    repeat (8) @(posedge CLOCK); #1;
    chk("rst_no_results", got_q.size(), 0);
    chk("rst_final_valid", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
